// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN layer datapath blocks.
// Contents:
//   CNN_DW      - default signed data width of a channel word
//   l2f_state_t - state encoding of the layer-2 feeder FSM
package cnn_pkg;

  localparam int CNN_DW = 18;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    WAIT   = 2'd2,
    DONE   = 2'd3
  } l2f_state_t;

endpackage

// File: rtl/pair_fifo.sv
// Two-word-wide FIFO holding channel-0/channel-1 result pairs.
// Parameters: DW (word width), DEPTH (entries, power of 2).
// Ports:
//   clk, rst      - clock, asynchronous active-high reset
//   push, wr_0/1  - write request and pair; ignored when full or flushing
//   pop           - read advance; ignored when empty or flushing
//   flush         - clears pointers and count, drops a same-cycle push
//   rd_0/1        - pair at the head (combinational)
//   count, full   - occupancy and full flag
module pair_fifo
  import cnn_pkg::*;
#(
  parameter int DW    = CNN_DW,
  parameter int DEPTH = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic signed [DW-1:0]       wr_0,
  input  logic signed [DW-1:0]       wr_1,
  output logic signed [DW-1:0]       rd_0,
  output logic signed [DW-1:0]       rd_1,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full
);

  localparam int AW = $clog2(DEPTH);

  logic signed [DW-1:0] mem_0 [DEPTH];
  logic signed [DW-1:0] mem_1 [DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic                 do_push;
  logic                 do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && (count != '0) && !flush;
  assign rd_0    = mem_0[rd_ptr];
  assign rd_1    = mem_1[rd_ptr];

  // Pointers are AW bits wide, so they wrap modulo DEPTH on their own.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage carries data only and needs no reset.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_0[wr_ptr] <= wr_0;
      mem_1[wr_ptr] <= wr_1;
    end
  end

endmodule

// File: rtl/l2_feeder.sv
// Layer-2 input stream transmitter. Buffers layer-1 result pairs and issues
// one convolution window at a time: strt with tap 0, then TAPS-1 further taps
// on consecutive cycles, paced by the engine busy flag and counted per frame.
// Optional build macro: L2_FEEDER_ERR_CHK_EN enables the sticky err flag
// (overflow push attempt, or tx_done aborting a window); otherwise err is 0.
// Ports:
//   clk, rst          - clock, asynchronous active-high reset
//   in_vld, in_0/1    - upstream pair; in_rdy = FIFO not full
//   bsy_in            - layer-2 engine busy
//   tx_done           - frame restart pulse, overrides everything
//   strt, dout_0/1    - registered window start and tap words
//   frame_end         - pulse after the last window of a frame
//   busy              - FSM in STREAM or WAIT
//   err               - sticky protocol error
module l2_feeder
  import cnn_pkg::*;
#(
  parameter int DW      = CNN_DW,
  parameter int TAPS    = 10,
  parameter int DEPTH   = 32,
  parameter int WINDOWS = 100
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_vld,
  input  logic signed [DW-1:0] in_0,
  input  logic signed [DW-1:0] in_1,
  output logic                 in_rdy,
  input  logic                 bsy_in,
  input  logic                 tx_done,
  output logic                 strt,
  output logic signed [DW-1:0] dout_0,
  output logic signed [DW-1:0] dout_1,
  output logic                 frame_end,
  output logic                 busy,
  output logic                 err
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int TW = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam int WW = $clog2(WINDOWS + 1);

  l2f_state_t           state;
  logic [TW-1:0]        tap_cnt;
  logic [WW-1:0]        win_cnt;
  logic                 wait_first;
  logic [CW-1:0]        count;
  logic                 full;
  logic signed [DW-1:0] rd_0;
  logic signed [DW-1:0] rd_1;
  logic                 issue;
  logic                 pop;

  pair_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (in_vld),
    .pop   (pop),
    .flush (tx_done),
    .wr_0  (in_0),
    .wr_1  (in_1),
    .rd_0  (rd_0),
    .rd_1  (rd_1),
    .count (count),
    .full  (full)
  );

  assign in_rdy = !full;
  assign busy   = (state == STREAM) || (state == WAIT);

  // A whole window must be buffered before issue so taps never stall.
  assign issue = (state == IDLE) && (count >= CW'(TAPS)) && !bsy_in &&
                 (win_cnt < WW'(WINDOWS));
  assign pop   = !tx_done && (issue || (state == STREAM));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      tap_cnt    <= '0;
      win_cnt    <= '0;
      wait_first <= 1'b0;
      strt       <= 1'b0;
      dout_0     <= '0;
      dout_1     <= '0;
      frame_end  <= 1'b0;
    end else begin
      // Outputs default to idle values; only tap cycles drive data.
      strt      <= 1'b0;
      frame_end <= 1'b0;
      dout_0    <= '0;
      dout_1    <= '0;
      if (tx_done) begin
        state      <= IDLE;
        tap_cnt    <= '0;
        win_cnt    <= '0;
        wait_first <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (issue) begin
              strt    <= 1'b1;
              dout_0  <= rd_0;
              dout_1  <= rd_1;
              win_cnt <= win_cnt + WW'(1);
              tap_cnt <= TW'(1);
              state   <= (TAPS > 1) ? STREAM : WAIT;
              wait_first <= (TAPS <= 1);
            end
          end
          STREAM: begin
            dout_0 <= rd_0;
            dout_1 <= rd_1;
            if (tap_cnt == TW'(TAPS - 1)) begin
              tap_cnt    <= '0;
              wait_first <= 1'b1;
              state      <= WAIT;
            end else begin
              tap_cnt <= tap_cnt + TW'(1);
            end
          end
          WAIT: begin
            // The engine raises bsy_out one cycle late, so the first WAIT
            // cycle cannot trust bsy_in.
            if (wait_first) begin
              wait_first <= 1'b0;
            end else if (!bsy_in) begin
              if (win_cnt == WW'(WINDOWS)) begin
                state     <= DONE;
                frame_end <= 1'b1;
              end else begin
                state <= IDLE;
              end
            end
          end
          DONE: begin
            state <= DONE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef L2_FEEDER_ERR_CHK_EN
  logic err_r;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_r <= 1'b0;
    end else if ((in_vld && !in_rdy) || (tx_done && (state == STREAM))) begin
      err_r <= 1'b1;
    end
  end

  assign err = err_r;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_l2_feeder.sv
// Directed bench for l2_feeder (WINDOWS=2 so frame completion is reachable).
module tb_l2_feeder;

  localparam int DW      = 18;
  localparam int TAPS    = 10;
  localparam int DEPTH   = 32;
  localparam int WINDOWS = 2;

`ifdef L2_FEEDER_ERR_CHK_EN
  localparam logic signed [31:0] ERR_EXP = 1;
`else
  localparam logic signed [31:0] ERR_EXP = 0;
`endif

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 in_vld = 1'b0;
  logic signed [DW-1:0] in_0 = '0;
  logic signed [DW-1:0] in_1 = '0;
  logic                 in_rdy;
  logic                 bsy_in = 1'b0;
  logic                 tx_done = 1'b0;
  logic                 strt;
  logic signed [DW-1:0] dout_0;
  logic signed [DW-1:0] dout_1;
  logic                 frame_end;
  logic                 busy;
  logic                 err;

  int vecs = 0;
  int errs = 0;
  logic seen;

  l2_feeder #(
    .DW      (DW),
    .TAPS    (TAPS),
    .DEPTH   (DEPTH),
    .WINDOWS (WINDOWS)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_vld    (in_vld),
    .in_0      (in_0),
    .in_1      (in_1),
    .in_rdy    (in_rdy),
    .bsy_in    (bsy_in),
    .tx_done   (tx_done),
    .strt      (strt),
    .dout_0    (dout_0),
    .dout_1    (dout_1),
    .frame_end (frame_end),
    .busy      (busy),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push_n(input int base, input int n);
    for (int k = 0; k < n; k++) begin
      in_vld = 1'b1;
      in_0   = DW'(base + k);
      in_1   = DW'(-(base + k));
      tick();
    end
    in_vld = 1'b0;
  endtask

  // Taps 1..TAPS-1 following an observed strt cycle.
  task automatic tap_checks(input int base, input string tag);
    for (int k = 1; k < TAPS; k++) begin
      tick();
      chk({tag, "_strt"}, strt, 0);
      chk({tag, "_d0"}, dout_0, base + k);
      chk({tag, "_d1"}, dout_1, -(base + k));
    end
  endtask

  initial begin
    // Reset values
    rst = 1'b1;
    tick();
    tick();
    chk("rst_strt", strt, 0);
    chk("rst_d0", dout_0, 0);
    chk("rst_d1", dout_1, 0);
    chk("rst_fe", frame_end, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_rdy", in_rdy, 1);
    rst = 1'b0;

    // Window 1: pairs 0..9, engine idle
    bsy_in = 1'b0;
    push_n(0, 10);
    chk("w1_not_yet", strt, 0);
    tick();
    chk("w1_strt", strt, 1);
    chk("w1_t0_d0", dout_0, 0);
    chk("w1_t0_d1", dout_1, 0);
    chk("w1_busy", busy, 1);
    bsy_in = 1'b1;
    tap_checks(0, "w1");
    tick();
    chk("w1_after_d0", dout_0, 0);
    chk("w1_after_d1", dout_1, 0);
    chk("w1_wait_busy", busy, 1);

    // Engine busy ~30 cycles while 20 more pairs arrive
    push_n(10, 20);
    chk("bsy_hold_strt", strt, 0);
    repeat (10) tick();
    chk("bsy_hold2_strt", strt, 0);
    chk("bsy_hold_busy", busy, 1);
    bsy_in = 1'b0;
    tick();
    chk("w2_not_early", strt, 0);
    tick();
    chk("w2_strt", strt, 1);
    chk("w2_t0_d0", dout_0, 10);
    chk("w2_t0_d1", dout_1, -10);
    tap_checks(10, "w2");

    // Frame end after the second window
    tick();
    chk("fe_early", frame_end, 0);
    tick();
    chk("fe_pulse", frame_end, 1);
    chk("done_busy", busy, 0);
    tick();
    chk("fe_one_cycle", frame_end, 0);
    seen = 1'b0;
    repeat (12) begin
      tick();
      if (strt) seen = 1'b1;
    end
    chk("done_no_issue", seen, 0);

    // tx_done restarts and flushes the 10 leftover pairs
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    chk("txd_busy", busy, 0);
    chk("txd_err", err, 0);
    seen = 1'b0;
    repeat (5) begin
      tick();
      if (strt) seen = 1'b1;
    end
    chk("txd_flushed", seen, 0);

    // Fill to full with engine busy; 33rd push dropped
    bsy_in = 1'b1;
    push_n(200, 31);
    chk("fill31_rdy", in_rdy, 1);
    push_n(231, 1);
    chk("fill32_rdy", in_rdy, 0);
    in_vld = 1'b1;
    in_0 = DW'(999);
    in_1 = DW'(-999);
    tick();
    in_vld = 1'b0;
    chk("ovf_err", err, ERR_EXP);
    chk("ovf_rdy", in_rdy, 0);
    chk("stall_strt", strt, 0);
    chk("stall_d0", dout_0, 0);

    // Issue from the full FIFO, then abort at tap 4
    bsy_in = 1'b0;
    tick();
    chk("w3_strt", strt, 1);
    chk("w3_t0_d0", dout_0, 200);
    repeat (4) tick();
    chk("w3_t4_d0", dout_0, 204);
    chk("w3_t4_d1", dout_1, -204);
    tx_done = 1'b1;
    in_vld = 1'b1;
    in_0 = DW'(555);
    in_1 = DW'(-555);
    tick();
    tx_done = 1'b0;
    in_vld = 1'b0;
    chk("abort_strt", strt, 0);
    chk("abort_d0", dout_0, 0);
    chk("abort_d1", dout_1, 0);
    chk("abort_busy", busy, 0);
    chk("abort_err", err, ERR_EXP);
    chk("abort_rdy", in_rdy, 1);
    seen = 1'b0;
    repeat (5) begin
      tick();
      if (strt) seen = 1'b1;
    end
    chk("abort_empty", seen, 0);

    // Asynchronous reset in the middle of a window
    push_n(300, 10);
    tick();
    chk("w4_strt", strt, 1);
    chk("w4_t0_d0", dout_0, 300);
    tick();
    tick();
    chk("w4_t2_d0", dout_0, 302);
    rst = 1'b1;
    #1;
    chk("arst_strt", strt, 0);
    chk("arst_d0", dout_0, 0);
    chk("arst_d1", dout_1, 0);
    chk("arst_busy", busy, 0);
    chk("arst_err", err, 0);
    chk("arst_fe", frame_end, 0);
    chk("arst_rdy", in_rdy, 1);
    tick();
    rst = 1'b0;
    seen = 1'b0;
    repeat (5) begin
      tick();
      if (strt) seen = 1'b1;
    end
    chk("arst_no_issue", seen, 0);
    push_n(400, 10);
    tick();
    chk("w5_strt", strt, 1);
    chk("w5_t0_d0", dout_0, 400);
    chk("w5_t0_d1", dout_1, -400);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/l2_feeder.md
# l2_feeder

Transmitter side of the layer-2 input stream. Buffers two-channel layer-1 result pairs in a FIFO and, one convolution window at a time, issues `strt` with TAPS consecutive `dout_0`/`dout_1` pairs to the layer-2 engine. It paces itself on the engine's busy flag, counts windows per frame and frames its work between `tx_done` pulses.

## Interface
- `DW`, 18: data width of each channel word (signed).
- `TAPS`, 10: pairs per window; the first is presented with `strt`.
- `DEPTH`, 32: FIFO depth in pairs. Power of 2, ≥ TAPS.
- `WINDOWS`, 100: windows per frame.
- `clk`  in  1  sole clock; all logic on posedge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_vld`  in  1  upstream pair valid.
- `in_0`, `in_1`  in  DW each  upstream channel-0/1 words.
- `in_rdy`  out  1  FIFO can accept a pair (count < DEPTH).
- `bsy_in`  in  1  layer-2 engine busy, from its `bsy_out`.
- `tx_done`  in  1  frame-transmit-complete pulse; restarts the frame.
- `strt`  out  1  one-cycle window-start pulse, registered.
- `dout_0`, `dout_1`  out  DW each  tap words, registered.
- `frame_end`  out  1  one-cycle pulse after the last window of a frame.
- `busy`  out  1  high in any state other than IDLE and DONE.
- `err`  out  1  sticky protocol-error flag (see Configuration).

## Operation
- FIFO: push on `in_vld && in_rdy`; pop once per tap cycle. Simultaneous push and pop leaves the count unchanged. There is no push-through when full. Pointers wrap modulo DEPTH.
- FSM (`l2f_state_t`): IDLE, STREAM, WAIT, DONE.
  - IDLE → STREAM when count ≥ TAPS, `bsy_in`=0 and win_cnt < WINDOWS. That edge registers `strt`=1 and tap 0 onto `dout_*`, pops one pair, and increments win_cnt.
  - STREAM: each cycle, registers the next tap and pops. tap_cnt runs 1..TAPS-1. After tap TAPS-1 is registered → WAIT.
  - WAIT: ignores `bsy_in` for the first cycle (engine latency), then exits on `bsy_in`=0. It goes to DONE if win_cnt == WINDOWS, otherwise to IDLE.
  - On entering DONE, `frame_end` pulses for one cycle. DONE holds with no issue until `tx_done`.
- `dout_*` are 0 in every cycle not carrying a tap. `strt` is high only with tap 0.
- `tx_done` in any state has priority over every other transition:
  - next state IDLE;
  - win_cnt, tap_cnt, FIFO pointers and count cleared;
  - `strt`, `dout_*` and `frame_end` go to 0 next cycle;
  - a push in the same cycle is dropped.
- Upstream data is consumed strictly in order. Pair k of a window maps to tap k.

## Timing
- Reset values: `strt`=0, `dout_0`=`dout_1`=0, `frame_end`=0, `busy`=0, `err`=0, `in_rdy`=1, state IDLE, all counters 0.
- Issue latency: with conditions met in IDLE at cycle c, `strt` and tap 0 are visible at c+1, and tap k at c+1+k.
- Minimum window-to-window spacing is TAPS+2 cycles (STREAM plus two WAIT cycles) when `bsy_in` is already low.
- `in_rdy` is combinational from count. The last free slot accepts a push, and `in_rdy` drops the next cycle.
- `bsy_in` high in IDLE stalls issue indefinitely, with no output change.

## Configuration
- `L2_FEEDER_ERR_CHK_EN` defined: `err` sets when either of these occurs, and clears only on `rst`:
  - `in_vld`=1 while `in_rdy`=0;
  - `tx_done` arrives while in STREAM (aborted window).
- Not defined: `err` is tied 0 and no check logic is built.

## Structure
- Shared package `cnn_pkg` holds the `l2f_state_t` enum and the default data width constant `CNN_DW`=18.
- Sub-module `pair_fifo` (params DW, DEPTH) provides two-word-wide storage with push, pop, flush, count and full. `l2_feeder` instantiates it once.
- The FSM, tap/window counters and output registers live in `l2_feeder`.

## Test plan
- Reset, then push 10 pairs (in_0=k, in_1=-k, k=0..9) with `bsy_in`=0 → `strt` for 1 cycle together with dout_0=0, dout_1=0; then dout_0=1..9 and dout_1=-1..-9 on consecutive cycles; then dout=0.
- Push 20 pairs and hold `bsy_in`=1 for 30 cycles after the first window → the second `strt` appears no earlier than 2 cycles after `bsy_in` falls, and carries pair 10.
- WINDOWS=2, 20 pairs, `bsy_in`=0 → two windows, then `frame_end` for exactly 1 cycle; 10 more pairs cause no `strt` until `tx_done`.
- Fill 32 pairs with no issue (`bsy_in`=1) → `in_rdy`=0. A 33rd `in_vld` is dropped and `err`=1 (macro defined) or `err`=0 (undefined).
- `tx_done` at tap 4 of a window → the next cycle has `dout`=0 and `strt`=0, count=0, `busy`=0; with the macro defined, `err`=1.
- Assert `rst` mid-STREAM → all outputs reach reset values immediately (async), with no `strt` until 10 new pairs are pushed.
